// File: rtl/manual_drive_ctrl.sv
// manual_drive_ctrl: manual-transmission drive FSM with power, stall, speed model, idle power-off and blinking turn lamps
module manual_drive_ctrl #(
  parameter int SPEED_W    = 8,
  parameter int MAX_SPEED  = 200,
  parameter int ACCEL      = 1,
  parameter int DECEL      = 1,
  parameter int IDLE_LIMIT = 1000,
  parameter int BLINK_HALF = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               manual_enable,
  input  logic               power_on_req,
  input  logic               clutch,
  input  logic               throttle,
  input  logic               brake,
  input  logic               reverse,
  input  logic               bu_left,
  input  logic               bu_right,
  output logic [1:0]         state,
  output logic               power,
  output logic [SPEED_W-1:0] speed,
  output logic               move_forward_signal,
  output logic               move_backward_signal,
  output logic               turn_left_signal,
  output logic               turn_right_signal,
  output logic               left_lamp,
  output logic               right_lamp,
  output logic               stall
);
  typedef enum logic [1:0] {OFF = 2'b00, NS = 2'b01, ST = 2'b10, MV = 2'b11} state_e;
  localparam int SW1 = SPEED_W + 1;
  localparam int IW  = $clog2(IDLE_LIMIT + 1);
  localparam int BW  = $clog2(BLINK_HALF + 1);
  state_e             state_q, state_d;
  logic               dir_q, dir_d, stall_q, stall_d, power_q, power_d;
  logic               fwd_q, fwd_d, bwd_q, bwd_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [IW-1:0]      idle_q, idle_d;
  logic [1:0]         turn_q, turn_d, lamp_q, lamp_d;
  logic [BW-1:0]      bcnt_q [2];
  logic [BW-1:0]      bcnt_d [2];
  logic               any_in, idle_hit;
  logic [SW1-1:0]     cur, inc, inc_sat, dec_amt, dec, spd_w;
  always_comb begin
    state_d  = state_q;
    stall_d  = 1'b0;
    dir_d    = dir_q;
    any_in   = clutch | throttle | brake | reverse | bu_left | bu_right;
    idle_hit = !any_in && idle_q == IW'(IDLE_LIMIT - 1);
    case (state_q)
      OFF: if (power_on_req) state_d = NS;
      NS: begin
        if (throttle && !clutch) begin
          state_d = OFF;
          stall_d = 1'b1;
        end else if (throttle && clutch && !brake) state_d = ST;
        else if (idle_hit) state_d = OFF;
      end
      ST: begin
        if (brake) state_d = NS;
        else if (throttle && !clutch) state_d = MV;
      end
      default: begin
        if (reverse != dir_q && !clutch) begin
          state_d = OFF;
          stall_d = 1'b1;
        end else if (brake || clutch || !throttle) state_d = ST;
      end
    endcase
    if (clutch && (state_q == NS || state_q == ST)) dir_d = reverse;
    idle_d  = (state_q == NS && !any_in) ? (idle_q == IW'(IDLE_LIMIT) ? idle_q : idle_q + IW'(1)) : '0;
    // Speed math carries one extra bit so neither saturation nor floor can wrap
    cur     = {1'b0, speed_q};
    inc     = cur + SW1'(ACCEL);
    inc_sat = inc > SW1'(MAX_SPEED) ? SW1'(MAX_SPEED) : inc;
    dec_amt = brake ? SW1'(2 * DECEL) : SW1'(DECEL);
    dec     = cur < dec_amt ? '0 : cur - dec_amt;
    spd_w   = (state_d == OFF || state_q == OFF || state_q == NS) ? '0 :
              (state_q == MV && throttle) ? inc_sat : !throttle ? dec : cur;
    speed_d = spd_w[SPEED_W-1:0];
    power_d = state_d != OFF;
    fwd_d   = state_d == MV && !dir_d;
    bwd_d   = state_d == MV && dir_d;
    turn_d  = {bu_right & !bu_left & state_d[1], bu_left & !bu_right & state_d[1]};
    lamp_d  = '0;
    for (int i = 0; i < 2; i++) begin
      bcnt_d[i] = (turn_d[i] && turn_q[i] && bcnt_q[i] != BW'(BLINK_HALF - 1)) ? bcnt_q[i] + BW'(1) : '0;
      lamp_d[i] = !turn_d[i] ? 1'b0 : !turn_q[i] ? 1'b1 :
                  bcnt_q[i] == BW'(BLINK_HALF - 1) ? !lamp_q[i] : lamp_q[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OFF;
      dir_q     <= 1'b0;
      stall_q   <= 1'b0;
      power_q   <= 1'b0;
      fwd_q     <= 1'b0;
      bwd_q     <= 1'b0;
      speed_q   <= '0;
      idle_q    <= '0;
      turn_q    <= '0;
      lamp_q    <= '0;
      bcnt_q[0] <= '0;
      bcnt_q[1] <= '0;
    end else if (manual_enable) begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      stall_q   <= stall_d;
      power_q   <= power_d;
      fwd_q     <= fwd_d;
      bwd_q     <= bwd_d;
      speed_q   <= speed_d;
      idle_q    <= idle_d;
      turn_q    <= turn_d;
      lamp_q    <= lamp_d;
      bcnt_q[0] <= bcnt_d[0];
      bcnt_q[1] <= bcnt_d[1];
    end
  end
  assign state                = state_q;
  assign power                = power_q;
  assign speed                = speed_q;
  assign stall                = stall_q;
  assign move_forward_signal  = fwd_q;
  assign move_backward_signal = bwd_q;
  assign turn_left_signal     = turn_q[0];
  assign turn_right_signal    = turn_q[1];
  assign left_lamp            = lamp_q[0];
  assign right_lamp           = lamp_q[1];
endmodule

// File: tb/tb_manual_drive_ctrl.sv
// tb_manual_drive_ctrl: directed scenario tests for manual_drive_ctrl with hand-computed expectations
module tb_manual_drive_ctrl;
  logic       clk = 0, rst_n = 0, manual_enable = 1, power_on_req = 0;
  logic       clutch = 0, throttle = 0, brake = 0, reverse = 0, bu_left = 0, bu_right = 0;
  logic [1:0] state;
  logic [7:0] speed;
  logic       power, fwd, bwd, tl, tr, ll, rl, stall;
  int         checks = 0, errors = 0;
  manual_drive_ctrl #(.SPEED_W(8), .MAX_SPEED(200), .ACCEL(1), .DECEL(1), .IDLE_LIMIT(10), .BLINK_HALF(4)) dut (
    .clk(clk), .rst_n(rst_n), .manual_enable(manual_enable), .power_on_req(power_on_req),
    .clutch(clutch), .throttle(throttle), .brake(brake), .reverse(reverse),
    .bu_left(bu_left), .bu_right(bu_right), .state(state), .power(power), .speed(speed),
    .move_forward_signal(fwd), .move_backward_signal(bwd), .turn_left_signal(tl),
    .turn_right_signal(tr), .left_lamp(ll), .right_lamp(rl), .stall(stall));
  always #5 clk = ~clk;
  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_in(logic t, logic r, logic c, logic b);
    throttle = t; reverse = r; clutch = c; brake = b;
  endtask
  task automatic power_up();
    power_on_req = 1; tick(); power_on_req = 0;
  endtask
  task automatic test_reset();
    rst_n = 0; set_in(0, 0, 0, 0); bu_left = 0; bu_right = 0; power_on_req = 0; manual_enable = 1;
    tick(2); rst_n = 1; tick();
    checks++; if (state !== 2'b00 || power !== 0 || speed !== 0) begin errors++; $display("FAIL reset_state: state=%b power=%b speed=%0d, want 00/0/0", state, power, speed); end
    checks++; if ({fwd, bwd, tl, tr, ll, rl, stall} !== 7'b0) begin errors++; $display("FAIL reset_outs: got %b want 0000000", {fwd, bwd, tl, tr, ll, rl, stall}); end
  endtask
  task automatic test_start_move();
    power_up();
    checks++; if (state !== 2'b01 || power !== 1) begin errors++; $display("FAIL power_on: state=%b power=%b, want 01/1", state, power); end
    power_on_req = 1; set_in(1, 0, 1, 0); tick(); power_on_req = 0;
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL ns_to_s: state=%b want 10", state); end
    power_on_req = 1; tick(); power_on_req = 0;
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL power_req_ignored: state=%b want 10", state); end
    set_in(1, 0, 0, 0); tick();
    checks++; if (state !== 2'b11 || fwd !== 1 || bwd !== 0 || speed !== 0) begin errors++; $display("FAIL s_to_m: state=%b fwd=%b bwd=%b speed=%0d, want 11/1/0/0", state, fwd, bwd, speed); end
    tick();
    checks++; if (speed !== 1) begin errors++; $display("FAIL accel1: speed=%0d want 1", speed); end
    tick();
    checks++; if (speed !== 2) begin errors++; $display("FAIL accel2: speed=%0d want 2", speed); end
  endtask
  task automatic test_saturate_coast();
    tick(198);
    checks++; if (speed !== 200) begin errors++; $display("FAIL reach_max: speed=%0d want 200", speed); end
    tick(52);
    checks++; if (speed !== 200 || state !== 2'b11) begin errors++; $display("FAIL hold_max: speed=%0d state=%b want 200/11", speed, state); end
    set_in(0, 0, 1, 0); tick();
    checks++; if (state !== 2'b10 || speed !== 199 || fwd !== 0) begin errors++; $display("FAIL coast1: state=%b speed=%0d fwd=%b want 10/199/0", state, speed, fwd); end
    tick();
    checks++; if (speed !== 198) begin errors++; $display("FAIL coast2: speed=%0d want 198", speed); end
    set_in(0, 0, 0, 1); tick();
    checks++; if (state !== 2'b01 || speed !== 196) begin errors++; $display("FAIL brake_to_ns: state=%b speed=%0d want 01/196", state, speed); end
    tick();
    checks++; if (state !== 2'b01 || speed !== 0) begin errors++; $display("FAIL ns_speed_zero: state=%b speed=%0d want 01/0", state, speed); end
  endtask
  task automatic test_stall_ns();
    set_in(1, 0, 0, 0); tick();
    checks++; if (state !== 2'b00 || power !== 0 || stall !== 1 || speed !== 0) begin errors++; $display("FAIL ns_stall: state=%b power=%b stall=%b speed=%0d want 00/0/1/0", state, power, stall, speed); end
    set_in(0, 0, 0, 0); tick();
    checks++; if (stall !== 0 || state !== 2'b00) begin errors++; $display("FAIL stall_pulse: stall=%b state=%b want 0/00", stall, state); end
  endtask
  task automatic test_reverse_stall();
    power_up();
    set_in(1, 1, 1, 0); tick();
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL rev_to_s: state=%b want 10", state); end
    set_in(1, 1, 0, 0); tick();
    checks++; if (state !== 2'b11 || bwd !== 1 || fwd !== 0) begin errors++; $display("FAIL rev_move: state=%b bwd=%b fwd=%b want 11/1/0", state, bwd, fwd); end
    tick();
    checks++; if (speed !== 1 || bwd !== 1) begin errors++; $display("FAIL rev_accel: speed=%0d bwd=%b want 1/1", speed, bwd); end
    set_in(1, 0, 0, 0); tick();
    checks++; if (state !== 2'b00 || stall !== 1 || bwd !== 0 || speed !== 0 || power !== 0) begin errors++; $display("FAIL rev_stall: state=%b stall=%b bwd=%b speed=%0d power=%b want 00/1/0/0/0", state, stall, bwd, speed, power); end
    set_in(0, 0, 0, 0); tick();
  endtask
  task automatic test_turn_lamps();
    power_up();
    bu_left = 1; tick();
    checks++; if (tl !== 0 || ll !== 0) begin errors++; $display("FAIL turn_in_ns: tl=%b ll=%b want 0/0", tl, ll); end
    bu_left = 0; set_in(1, 0, 1, 0); tick();
    set_in(1, 0, 0, 0); tick();
    checks++; if (state !== 2'b11 || speed !== 0) begin errors++; $display("FAIL turn_setup: state=%b speed=%0d want 11/0", state, speed); end
    bu_left = 1;
    for (int k = 0; k < 16; k++) begin
      logic exp_lamp;
      exp_lamp = ((k / 4) % 2) == 0;
      tick();
      checks++; if (tl !== 1 || tr !== 0 || ll !== exp_lamp || rl !== 0) begin errors++; $display("FAIL blink[%0d]: tl=%b tr=%b ll=%b rl=%b want 1/0/%b/0", k, tl, tr, ll, rl, exp_lamp); end
    end
    checks++; if (speed !== 16) begin errors++; $display("FAIL turn_speed: speed=%0d want 16", speed); end
    bu_right = 1; tick();
    checks++; if ({tl, tr, ll, rl} !== 4'b0000 || speed !== 17) begin errors++; $display("FAIL both_buttons: tl/tr/ll/rl=%b speed=%0d want 0000/17", {tl, tr, ll, rl}, speed); end
    bu_left = 0; tick();
    checks++; if (tr !== 1 || rl !== 1 || tl !== 0) begin errors++; $display("FAIL right_turn: tr=%b rl=%b tl=%b want 1/1/0", tr, rl, tl); end
    manual_enable = 0; set_in(0, 0, 0, 1); bu_right = 0; tick(3);
    checks++; if (state !== 2'b11 || speed !== 18 || rl !== 1 || fwd !== 1) begin errors++; $display("FAIL freeze: state=%b speed=%0d rl=%b fwd=%b want 11/18/1/1", state, speed, rl, fwd); end
    manual_enable = 1; set_in(1, 0, 0, 0); tick(2);
  endtask
  task automatic test_async_reset();
    @(posedge clk); #3 rst_n = 0; #1;
    checks++; if (state !== 2'b00 || speed !== 0 || fwd !== 0 || power !== 0) begin errors++; $display("FAIL async_reset: state=%b speed=%0d fwd=%b power=%b want 00/0/0/0", state, speed, fwd, power); end
    set_in(0, 0, 0, 0); tick(); rst_n = 1; tick();
  endtask
  task automatic test_idle_off();
    power_up();
    tick(9);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL idle_before: state=%b want 01", state); end
    tick();
    checks++; if (state !== 2'b00 || stall !== 0 || power !== 0) begin errors++; $display("FAIL idle_off: state=%b stall=%b power=%b want 00/0/0", state, stall, power); end
    power_up();
    tick(8);
    clutch = 1; tick(); clutch = 0;
    tick(9);
    checks++; if (state !== 2'b01) begin errors++; $display("FAIL idle_restart: state=%b want 01", state); end
    tick();
    checks++; if (state !== 2'b00 || stall !== 0) begin errors++; $display("FAIL idle_off2: state=%b stall=%b want 00/0", state, stall); end
  endtask
  initial begin
    test_reset();
    test_start_move();
    test_saturate_coast();
    test_stall_ns();
    test_reverse_stall();
    test_turn_lamps();
    test_async_reset();
    test_idle_off();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/manual_drive_ctrl.md
# manual_drive_ctrl

Parametrised manual-transmission drive controller for the car simulation: the next generation of the manual-mode state machine. Sits between the debounced cockpit inputs (clutch, throttle, brake, reverse, turn buttons) and the motion and lamp drivers. Adds power-on/off, stall detection, a saturating speed model, idle auto power-off and blinking turn lamps on top of the basic not-starting/starting/moving sequencing.

## Interface
- SPEED_W, 8, width of speed register
- MAX_SPEED, 200, speed saturation value (must be < 2^SPEED_W)
- ACCEL, 1, speed increment per cycle while accelerating
- DECEL, 1, speed decrement per cycle while coasting (braking uses 2*DECEL)
- IDLE_LIMIT, 1000, idle cycles in NOT_STARTING before auto power-off (≥1)
- BLINK_HALF, 50, lamp half-period in cycles (≥1)

- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- manual_enable  in  1  manual mode select; 0 freezes the controller
- power_on_req  in  1  request power-up from OFF
- clutch, throttle, brake, reverse  in  1 each  pedal/lever levels
- bu_left, bu_right  in  1 each  turn buttons
- state  out  2  OFF=00, NOT_STARTING=01, STARTING=10, MOVING=11
- power  out  1  1 when state != OFF
- speed  out  SPEED_W  current speed
- move_forward_signal, move_backward_signal  out  1 each  motion commands
- turn_left_signal, turn_right_signal  out  1 each  turn commands
- left_lamp, right_lamp  out  1 each  blinking indicator lamps
- stall  out  1  one-cycle pulse on engine stall

## Operation
- All outputs registered; inputs sampled on rising clk. manual_enable=0: every register holds its value.
- dir register (0 fwd, 1 rev): loads reverse whenever clutch=1 and state ∈ {NS, S}.
- Transitions, first matching rule wins:
  - OFF: power_on_req → NS.
  - NS: throttle & !clutch → OFF, stall=1. throttle & clutch & !brake → S. idle count reaches IDLE_LIMIT → OFF (no stall). Else NS.
  - S: brake → NS. throttle & !clutch → M. Else S.
  - M: reverse != dir & !clutch → OFF, stall=1. brake | clutch | !throttle → S. Else M.
- Speed:
  - M with throttle: speed ← min(speed+ACCEL, MAX_SPEED).
  - S or M without throttle: speed ← max(speed − (brake ? 2*DECEL : DECEL), 0).
  - NS, OFF, or any transition into OFF: speed ← 0.
  - Arithmetic in SPEED_W+1 bits, no wrap.
- Motion: move_forward_signal = (next state M) & !dir; move_backward_signal = (next state M) & dir; both 0 otherwise.
- Turn: turn_left_signal ← bu_left & !bu_right & next state ∈ {S, M}; right symmetric. Both buttons pressed → both 0.
- Lamps: blink counter clears and lamp ← 1 on the cycle turn signal rises; toggles every BLINK_HALF cycles while held; lamp ← 0 the cycle the signal drops.
- Idle counter: counts in NS while all of clutch, throttle, brake, reverse, bu_left, bu_right are 0; any input active or leaving NS clears it. Saturates at IDLE_LIMIT.

## Timing
- Reset (async assert, sync-released logic): state=OFF, power=0, speed=0, dir=0, stall=0, all motion/turn/lamp outputs 0, counters 0.
- Latency: input change → state/power/speed/motion/turn outputs one clk edge later.
- stall high exactly one cycle, same cycle state first reads OFF.
- Reset mid-MOVING: outputs reach reset values immediately, independent of clk.
- Simultaneous brake+throttle in S: brake wins (→ NS). power_on_req while powered: ignored.
- Speed at MAX_SPEED with throttle: holds MAX_SPEED. Speed below DECEL while coasting: goes to 0.

## Test plan
- Reset, power_on_req=1 one cycle → state=01, power=1; {throttle,reverse,clutch,brake}=1010 → state=10; then 1000 → state=11, move_forward_signal=1, speed +1 per cycle.
- Hold 1000 in MOVING 250 cycles (MAX_SPEED=200) → speed saturates at 200; then 0010 → state=10, speed 200→199→…; then 0001 → state=01, speed=0.
- In NS apply 1000 (throttle, no clutch) → stall pulse one cycle, state=00, power=0, speed=0.
- Enter M with 1110 then 1100 → move_backward_signal=1; drop reverse with clutch=0 → stall, state=00.
- In M, bu_left=1 (BLINK_HALF=4) → turn_left_signal=1, left_lamp 1 for 4 cycles, 0 for 4, repeating; bu_left=bu_right=1 → both 0.
- Idle in NS with IDLE_LIMIT=10 → state=00 after 10 cycles, stall=0; a clutch tap at cycle 9 restarts the count.
